// File: rtl/dac_pkg.sv
// Shared definitions for the MCP4921 DAC write path: FSM states and frame layout.
package dac_pkg;

  localparam int unsigned FRAME_BITS_DEF = 16;
  localparam int unsigned EDGE_CNT_W     = 5;

  localparam int unsigned AB_POS   = 15;
  localparam int unsigned BUF_POS  = 14;
  localparam int unsigned GA_POS   = 13;
  localparam int unsigned SHDN_POS = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TAIL  = 2'd2,
    ST_GAP   = 2'd3
  } dac_state_t;

endpackage

// File: rtl/dac_writer_sck_tick_gen.sv
// Half-period tick generator for the DAC SPI clock: one-cycle tick every CLK_DIV
// clk_dac cycles while not cleared.
module sck_tick_gen #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick_c = !i_clr && (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dac_writer.sv
// SPI write-frame serialiser for an MCP4921 DAC (mode 0,0, MSB first).
// Define LDAC_PULSE_EN to strobe ldac_n low during the post-frame gap; otherwise ldac_n is held 0.
module dac_writer
  import dac_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 12,
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned BUF_BIT    = 0,
  parameter int unsigned GAIN_1X    = 1
) (
  input  logic                 clk_dac,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] datos_dac,
  input  logic                 shutdown,
  output logic                 chip_select,
  output logic                 sck_dac,
  output logic                 sdi_dac,
  output logic                 ldac_n,
  output logic                 busy,
  output logic                 done
);

`ifdef LDAC_PULSE_EN
  localparam logic LDAC_IDLE = 1'b1;
`else
  localparam logic LDAC_IDLE = 1'b0;
`endif

  dac_state_t                r_state, w_state_nxt;
  logic [FRAME_BITS-1:0]     r_shift, w_shift_nxt;
  logic [EDGE_CNT_W-1:0]     r_edge_cnt, w_edge_nxt;
  logic                      r_cs, w_cs_nxt;
  logic                      r_sck, w_sck_nxt;
  logic                      r_sdi, w_sdi_nxt;
  logic                      r_ldac_n, w_ldac_nxt;
  logic                      r_busy, w_busy_nxt;
  logic                      r_done, w_done_nxt;
  logic [FRAME_BITS-1:0]     w_frame;
  logic                      w_tick;
  logic                      w_clr;
  logic                      w_accept;

  assign w_clr = (r_state == ST_IDLE);

  sck_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk    (clk_dac),
    .i_rst    (reset),
    .i_clr    (w_clr),
    .o_tick_c (w_tick)
  );

  // Command frame: {A/B, BUF, GA_n, SHDN_n, data}
  always_comb begin
    w_frame                 = '0;
    w_frame[DATA_BITS-1:0]  = datos_dac;
    w_frame[AB_POS]         = 1'b0;
    w_frame[BUF_POS]        = 1'(BUF_BIT);
    w_frame[GA_POS]         = 1'(GAIN_1X);
    w_frame[SHDN_POS]       = ~shutdown;
  end

  always_ff @(posedge clk_dac or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_edge_nxt  = r_edge_cnt;
    w_cs_nxt    = r_cs;
    w_sck_nxt   = r_sck;
    w_sdi_nxt   = r_sdi;
    w_ldac_nxt  = r_ldac_n;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_accept = start;
      end
      ST_SHIFT: begin
        if (w_tick) begin
          if (!r_sck) begin
            w_sck_nxt  = 1'b1;
            w_edge_nxt = r_edge_cnt + EDGE_CNT_W'(1);
          end else begin
            w_sck_nxt = 1'b0;
            if (r_edge_cnt == EDGE_CNT_W'(FRAME_BITS)) begin
              w_state_nxt = ST_TAIL;
            end else begin
              w_shift_nxt = {r_shift[FRAME_BITS-2:0], 1'b0};
              w_sdi_nxt   = r_shift[FRAME_BITS-2];
            end
          end
        end
      end
      ST_TAIL: begin
        if (w_tick) begin
          w_cs_nxt    = 1'b1;
          w_sdi_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
          w_ldac_nxt  = 1'b0;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_tick) begin
          w_ldac_nxt = LDAC_IDLE;
          // End of tCSH doubles as an IDLE sample so held start gives back-to-back frames
          if (start) begin
            w_accept = 1'b1;
          end else begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_accept) begin
      w_shift_nxt = w_frame;
      w_sdi_nxt   = w_frame[FRAME_BITS-1];
      w_edge_nxt  = '0;
      w_sck_nxt   = 1'b0;
      w_cs_nxt    = 1'b0;
      w_busy_nxt  = 1'b1;
      w_state_nxt = ST_SHIFT;
    end
  end

  always_ff @(posedge clk_dac or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_edge_cnt <= '0;
      r_cs       <= 1'b1;
      r_sck      <= 1'b0;
      r_sdi      <= 1'b0;
      r_ldac_n   <= LDAC_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_shift    <= w_shift_nxt;
      r_edge_cnt <= w_edge_nxt;
      r_cs       <= w_cs_nxt;
      r_sck      <= w_sck_nxt;
      r_sdi      <= w_sdi_nxt;
      r_ldac_n   <= w_ldac_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign chip_select = r_cs;
  assign sck_dac     = r_sck;
  assign sdi_dac     = r_sdi;
  assign ldac_n      = r_ldac_n;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_dac_writer.sv
// Scoreboard bench for dac_writer: one instance at CLK_DIV=1, one at CLK_DIV=4.
module tb_dac_writer;

  localparam int unsigned DIV0 = 1;
  localparam int unsigned DIV1 = 4;

  logic        clk = 1'b0;
  logic [1:0]  rst_s;
  logic [1:0]  start_s;
  logic [1:0]  shut_s;
  logic [11:0] dat_s [2];
  wire  [1:0]  cs_w, sck_w, sdi_w, ldac_w, busy_w, done_w;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  int          cs_low [2];
  int          nbits [2];
  int          last_rise [2];
  int          ldac_left [2];
  logic [15:0] bits [2];
  logic        cs_p [2];
  logic        sck_p [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_writer #(.CLK_DIV(DIV0)) u_dut0 (
    .clk_dac     (clk),
    .reset       (rst_s[0]),
    .start       (start_s[0]),
    .datos_dac   (dat_s[0]),
    .shutdown    (shut_s[0]),
    .chip_select (cs_w[0]),
    .sck_dac     (sck_w[0]),
    .sdi_dac     (sdi_w[0]),
    .ldac_n      (ldac_w[0]),
    .busy        (busy_w[0]),
    .done        (done_w[0])
  );

  dac_writer #(.CLK_DIV(DIV1)) u_dut1 (
    .clk_dac     (clk),
    .reset       (rst_s[1]),
    .start       (start_s[1]),
    .datos_dac   (dat_s[1]),
    .shutdown    (shut_s[1]),
    .chip_select (cs_w[1]),
    .sck_dac     (sck_w[1]),
    .sdi_dac     (sdi_w[1]),
    .ldac_n      (ldac_w[1]),
    .busy        (busy_w[1]),
    .done        (done_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int div_of(input int d);
    return (d == 0) ? int'(DIV0) : int'(DIV1);
  endfunction

  function automatic logic [15:0] exp_frame(input logic [11:0] data, input logic sd);
    return {1'b0, 1'b0, 1'b1, ~sd, data};
  endfunction

  task automatic push(input int d, input logic [15:0] f);
    if (d == 0) q0.push_back(f);
    else        q1.push_back(f);
  endtask

  // Per-cycle monitor: collects bits on sck rise, scores the frame when chip_select rises
  task automatic mon(input int d, input logic cs, input logic sck, input logic sdi,
                     input logic dn, input logic ldac, input logic rst);
    logic        rose;
    logic        exp_ldac;
    logic [15:0] want;
    int          qn;
    if (rst) begin
      cs_p[d] = 1'b1; sck_p[d] = 1'b0; nbits[d] = 0; cs_low[d] = 0; ldac_left[d] = 0;
    end else begin
      rose = cs && !cs_p[d];
      if (rose) ldac_left[d] = div_of(d);
`ifdef LDAC_PULSE_EN
      exp_ldac = (ldac_left[d] > 0) ? 1'b0 : 1'b1;
`else
      exp_ldac = 1'b0;
`endif
      check($sformatf("ldac_n%0d", d), ldac, exp_ldac);
      if (ldac_left[d] > 0) ldac_left[d]--;
      check($sformatf("done%0d", d), dn, rose);
      if (cs) begin
        check($sformatf("sdi_idle%0d", d), sdi, 1'b0);
        check($sformatf("sck_idle%0d", d), sck, 1'b0);
      end else begin
        cs_low[d]++;
        if (sck && !sck_p[d]) begin
          if (nbits[d] > 0) check($sformatf("sck_period%0d", d), cyc - last_rise[d], 2 * div_of(d));
          last_rise[d] = cyc;
          bits[d] = {bits[d][14:0], sdi};
          nbits[d]++;
        end
      end
      if (rose) begin
        qn = (d == 0) ? q0.size() : q1.size();
        check($sformatf("frame_expected%0d", d), (qn != 0), 1'b1);
        if (qn != 0) begin
          want = (d == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("frame%0d", d), bits[d], want);
        end
        check($sformatf("nbits%0d", d), nbits[d], 16);
        check($sformatf("cs_low%0d", d), cs_low[d], 33 * div_of(d));
        nbits[d] = 0;
        cs_low[d] = 0;
      end
      cs_p[d] = cs;
      sck_p[d] = sck;
    end
  endtask

  always @(negedge clk) begin
    mon(0, cs_w[0], sck_w[0], sdi_w[0], done_w[0], ldac_w[0], rst_s[0]);
    mon(1, cs_w[1], sck_w[1], sdi_w[1], done_w[1], ldac_w[1], rst_s[1]);
  end

  // Single frame with optional mid-frame start pulse (cycles after acceptance)
  task automatic send(input int d, input logic [11:0] data, input logic sd, input int mid_at);
    int t_done;
    int div;
    div = div_of(d);
    t_done = -1;
    @(posedge clk); #1;
    start_s[d] = 1'b1; dat_s[d] = data; shut_s[d] = sd;
    push(d, exp_frame(data, sd));
    @(posedge clk); #1;
    start_s[d] = 1'b0; dat_s[d] = ~data; shut_s[d] = ~sd;
    check("accept_cs", cs_w[d], 1'b0);
    check("accept_busy", busy_w[d], 1'b1);
    for (int n = 1; n <= 40 * div; n++) begin
      if (n == mid_at) begin
        start_s[d] = 1'b1; dat_s[d] = 12'h123;
      end else if (n == mid_at + 1) begin
        start_s[d] = 1'b0;
      end
      @(posedge clk); #1;
      if (done_w[d]) begin
        t_done = n;
        break;
      end
    end
    check("start_to_done", t_done, 33 * div);
    check("busy_at_done", busy_w[d], 1'b1);
    repeat (div) @(posedge clk);
    #1;
    check("busy_released", busy_w[d], 1'b0);
  endtask

  logic [11:0] b2b [3];

  initial begin
    int rises;
    logic sck_prev;
    b2b[0] = 12'h111; b2b[1] = 12'h9C3; b2b[2] = 12'h0F0;
    rst_s = 2'b11; start_s = '0; shut_s = '0;
    dat_s[0] = '0; dat_s[1] = '0;
    #1;
    check("rst_cs", cs_w[0], 1'b1);
    check("rst_sck", sck_w[0], 1'b0);
    check("rst_sdi", sdi_w[0], 1'b0);
    check("rst_busy", busy_w[0], 1'b0);
    check("rst_done", done_w[0], 1'b0);
`ifdef LDAC_PULSE_EN
    check("rst_ldac", ldac_w[0], 1'b1);
`else
    check("rst_ldac", ldac_w[0], 1'b0);
`endif
    repeat (3) @(posedge clk);
    #1 rst_s = 2'b00;
    repeat (2) @(posedge clk);

    send(0, 12'hA5C, 1'b0, 0);
    send(0, 12'hFFF, 1'b1, 0);
    send(1, 12'h001, 1'b0, 0);
    send(0, 12'hABC, 1'b0, 10);
    repeat (5) @(posedge clk);
    #1;
    check("no_refire_cs", cs_w[0], 1'b1);
    check("no_refire_busy", busy_w[0], 1'b0);

    // Abort at the 10th sck rise, then recover with a full frame
    @(posedge clk); #1;
    start_s[0] = 1'b1; dat_s[0] = 12'h5A3; shut_s[0] = 1'b0;
    push(0, exp_frame(12'h5A3, 1'b0));
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    rises = 0;
    sck_prev = sck_w[0];
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (sck_w[0] && !sck_prev) rises++;
      sck_prev = sck_w[0];
      if (rises == 10) break;
    end
    check("abort_reached", rises, 10);
    rst_s[0] = 1'b1;
    #1;
    check("abort_cs", cs_w[0], 1'b1);
    check("abort_sck", sck_w[0], 1'b0);
    check("abort_busy", busy_w[0], 1'b0);
    if (q0.size() != 0) void'(q0.pop_front());
    repeat (2) @(posedge clk);
    #1 rst_s[0] = 1'b0;
    send(0, 12'h7E1, 1'b0, 0);

    // Start held high: three back-to-back frames, 34 cycles apart
    @(posedge clk); #1;
    start_s[0] = 1'b1; dat_s[0] = b2b[0]; shut_s[0] = 1'b0;
    push(0, exp_frame(b2b[0], 1'b0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("b2b_accept_cs", cs_w[0], 1'b0);
      if (k < 2) begin
        dat_s[0] = b2b[k + 1];
        push(0, exp_frame(b2b[k + 1], 1'b0));
        repeat (33) @(posedge clk);
      end else begin
        start_s[0] = 1'b0;
      end
    end
    repeat (40) @(posedge clk);
    #1;
    check("b2b_idle_busy", busy_w[0], 1'b0);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
